// File: rtl/piso_serializer.sv
// ============================================================================
// Module   : piso_serializer
// Brief    : Parallel-in/serial-out stage, MSB first, valid/ready load,
//            back-to-back frames, synchronous flush, wrapping frame counter.
//            Optional trailing even-parity bit when PISO_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             flush,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             frame_last,
    output logic [CNT_W-1:0] frame_cnt
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int              BCNT_W = $clog2(WIDTH + 1);
    localparam logic [BCNT_W-1:0] c_LAST = BCNT_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   w_sr_nxt;
    logic [BCNT_W-1:0]  r_bcnt;
    logic [BCNT_W-1:0]  w_bcnt_nxt;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   w_frame_cnt_nxt;
    logic               r_rdy_en;
    logic               w_busy;
    logic               w_last;
    logic               w_accept;
    logic               w_dout;

    assign w_busy   = (r_state == SHIFT);
    assign w_last   = w_busy && (r_bcnt == c_LAST);
    // r_rdy_en keeps load_ready low until the first edge after reset release
    assign w_accept = load_valid && load_ready;

    always_comb begin
        load_ready = r_rdy_en && !flush && (!w_busy || w_last);
    end

`ifdef PISO_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_par <= 1'b0;
        end else if (flush) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= ^load_data;
        end
    end

    // Once the LSB has left, the parity flop supplies the trailing bit
    assign w_dout = (r_bcnt == BCNT_W'(WIDTH)) ? r_par : r_sr[WIDTH-1];
`else
    assign w_dout = r_sr[WIDTH-1];
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_sr_nxt        = r_sr;
        w_bcnt_nxt      = r_bcnt;
        w_frame_cnt_nxt = r_frame_cnt;

        if (flush) begin
            w_state_nxt = IDLE;
            w_sr_nxt    = '0;
            w_bcnt_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_sr_nxt    = load_data;
                        w_bcnt_nxt  = '0;
                        w_state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                        if (w_accept) begin
                            w_sr_nxt   = load_data;
                            w_bcnt_nxt = '0;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_sr_nxt   = {r_sr[WIDTH-2:0], 1'b0};
                        w_bcnt_nxt = r_bcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= IDLE;
            r_sr        <= '0;
            r_bcnt      <= '0;
            r_frame_cnt <= '0;
            r_rdy_en    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_bcnt      <= w_bcnt_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_rdy_en    <= 1'b1;
        end
    end

    always_comb begin
        dout        = w_busy && w_dout;
        dout_valid  = w_busy;
        frame_start = w_busy && (r_bcnt == '0);
        frame_last  = w_last;
        frame_cnt   = r_frame_cnt;
    end

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: frame-level reference model compared every cycle,
// plus directed vectors with hand-computed expectations.
`default_nettype none

module tb_piso_serializer;

    localparam int W     = 8;
    localparam int CNT_W = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic             clk = 1'b0;
    logic             clr_n;
    logic             flush;
    logic             load_valid;
    logic [W-1:0]     load_data;
    logic             load_ready;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             frame_last;
    logic [CNT_W-1:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    piso_serializer #(.WIDTH(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .flush       (flush),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .frame_last  (frame_last),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: which word is in flight and which bit position of it is on the wire
    logic             m_busy   = 1'b0;
    int               m_pos    = 0;
    logic [W-1:0]     m_word   = '0;
    logic [CNT_W-1:0] m_cnt    = '0;
    logic             m_rdy_en = 1'b0;
    logic             m_acc    = 1'b0;
    logic             m_ready;

    assign m_ready = m_rdy_en && !flush && (!m_busy || m_pos == FL - 1);

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_busy   <= 1'b0;
            m_pos    <= 0;
            m_word   <= '0;
            m_cnt    <= '0;
            m_rdy_en <= 1'b0;
            m_acc    <= 1'b0;
        end else begin
            m_rdy_en <= 1'b1;
            m_acc    <= load_valid && m_ready;
            if (flush) begin
                m_busy <= 1'b0;
                m_pos  <= 0;
            end else begin
                if (m_busy && m_pos == FL - 1) m_cnt <= m_cnt + 1'b1;
                if (load_valid && m_ready) begin
                    m_word <= load_data;
                    m_pos  <= 0;
                    m_busy <= 1'b1;
                end else if (m_busy && m_pos < FL - 1) begin
                    m_pos <= m_pos + 1;
                end else begin
                    m_busy <= 1'b0;
                end
            end
        end
    end

    function automatic logic exp_bit(input logic [W-1:0] word, input int pos);
        if (pos < W) return word[W-1-pos];
        return ^word;
    endfunction

    always @(negedge clk) begin
        chk("dout",        dout,        m_busy && exp_bit(m_word, m_pos));
        chk("dout_valid",  dout_valid,  m_busy);
        chk("frame_start", frame_start, m_busy && m_pos == 0);
        chk("frame_last",  frame_last,  m_busy && m_pos == FL - 1);
        chk("frame_cnt",   frame_cnt,   m_cnt);
        chk("load_ready",  load_ready,  m_ready);
    end

    // Downstream left shifter clocked on dout_valid
    logic [31:0] ds;
    always @(posedge clk) if (dout_valid) ds <= {ds[30:0], dout};

    int run = 0;
    int last_run = 0;
    always @(negedge clk) begin
        if (dout_valid) run <= run + 1;
        else begin
            if (run != 0) last_run <= run;
            run <= 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w, input bit keep);
        bit got = 1'b0;
        load_valid = 1'b1;
        load_data  = w;
        for (int i = 0; i < 64 && !got; i++) begin
            @(posedge clk);
            #1;
            got = m_acc;
        end
        if (!got) chk("accept_timeout", 0, 1);
        if (!keep) load_valid = 1'b0;
    endtask

    initial begin
        clr_n = 1'b0; flush = 1'b0; load_valid = 1'b0; load_data = '0;
        @(posedge clk); #1;
        chk("rst_dout",       dout,       0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_frame_cnt",  frame_cnt,  0);
        chk("rst_load_ready", load_ready, 0);
        idle(1);
        #3 clr_n = 1'b1;
        idle(1);
        chk("ready_after_rst", load_ready, 1);

        // Single frame
        send(8'hA5, 0);
        idle(12);
`ifdef PISO_PARITY_EN
        chk("a5_downstream", ds[8:0], {8'hA5, 1'b0});
`else
        chk("a5_downstream", ds[7:0], 8'hA5);
`endif
        chk("a5_frame_cnt", frame_cnt, 1);
        chk("a5_idle_after", dout_valid, 0);

        // Back-to-back frames
        send(8'h3C, 1);
        send(8'hFF, 0);
        idle(2 * FL + 4);
        chk("b2b_run_len", last_run, 2 * FL);
        chk("b2b_frame_cnt", frame_cnt, 3);

        // Flush at bit 4 with a competing load
        send(8'h81, 0);
        idle(4);
        flush = 1'b1; load_valid = 1'b1; load_data = 8'h5A;
        #1;
        chk("flush_ready_low", load_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; load_valid = 1'b0;
        chk("flush_valid_low", dout_valid, 0);
        chk("flush_cnt_hold", frame_cnt, 3);
        idle(3);
        chk("flush_not_accepted", dout_valid, 0);

        // Asynchronous reset mid-frame
        send(8'h5A, 0);
        idle(3);
        #2 clr_n = 1'b0;
        #1;
        chk("arst_dout",       dout,       0);
        chk("arst_dout_valid", dout_valid, 0);
        chk("arst_frame_cnt",  frame_cnt,  0);
        chk("arst_load_ready", load_ready, 0);
        #2 clr_n = 1'b1;
        idle(1);
        send(8'h5A, 0);
        idle(12);
`ifdef PISO_PARITY_EN
        chk("5a_downstream", ds[8:0], {8'h5A, 1'b0});
`else
        chk("5a_downstream", ds[7:0], 8'h5A);
`endif
        chk("5a_frame_cnt", frame_cnt, 1);

        // Counter wrap: 1 + 255 frames lands on 0, one more gives 1
        for (int i = 0; i < 255; i++) send(8'h00, i < 254);
        idle(FL + 3);
        chk("wrap_zero", frame_cnt, 0);
        send(8'h00, 0);
        idle(FL + 3);
        chk("wrap_one", frame_cnt, 1);

`ifdef PISO_PARITY_EN
        send(8'h07, 0);
        idle(12);
        chk("par_07", ds[8:0], 9'h00F);
        send(8'h03, 0);
        idle(12);
        chk("par_03", ds[8:0], 9'h006);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
